serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//  Bit-serial two's-complement adder/subtractor built around one full-adder cell.
//  Accepts operand pairs over a valid/ready handshake and processes one bit per clock, LSB first.
//  Returns the sum or difference with carry and signed-overflow flags over a second valid/ready handshake.
//  Area-lean arithmetic for the datapath, used where throughput below 1 result per WIDTH cycles is acceptable.
// PARAMETERS
//  WIDTH  8  operand/result width in bits, >= 2
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  in_valid   in   1      operands a, b, sub presented
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      0: y = a + b; 1: y = a - b
//  out_valid  out  1      y, cout and ovf hold a result
//  out_ready  in   1      consumer accepts the result
//  y          out  WIDTH  result
//  cout       out  1      carry out of the MSB; for subtract, 1 = no borrow (a >= b unsigned)
//  ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  Reset (async assert, any state): FSM to IDLE.
//   in_ready=1, out_valid=0, y=0, cout=0, ovf=0; shift registers, carry and counter cleared.
//  FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid: latch a, b^{WIDTH{sub}} and sub; carry<=sub; cnt<=0; go to SHIFT.
//  SHIFT:
//   - in_ready=0, out_valid=0.
//   - Each cycle, the cell computes s, c from (a_sr[0], b_sr[0], carry).
//   - s shifts into the MSB of res_sr; a_sr and b_sr shift right; carry<=c; cnt++.
//   - On cnt==WIDTH-1, capture the outputs and go to DONE:
//     y<=final res_sr, cout<=c, ovf<=carry_in_msb^c.
//  DONE:
//   - out_valid=1.
//   - y, cout and ovf stay stable until out_valid&&out_ready; then go to IDLE.
//   - No overlap: in_ready=0 in DONE, so in_valid there is ignored and not captured.
//  Latency: operand accepted at edge N gives out_valid=1 after edge N+WIDTH.
//   Minimum initiation interval is WIDTH+2 cycles.
//  y, cout and ovf are updated only on SHIFT->DONE and hold their last value in IDLE.
//  Counter width is $clog2(WIDTH); it never wraps, because SHIFT exits at WIDTH-1.
//  Reset mid-SHIFT or mid-DONE discards the operation; no partial result is ever presented.
// CONFIGURATION
//  SERIAL_ADDSUB_SAT_EN defined:
//   - If ovf=1 at capture, y saturates to the signed limit: 0111..1 if the operand sign
//     (a MSB) is 0, else 1000..0.
//   - ovf still reports 1.
//  Not defined: y is the wrapped modulo-2^WIDTH result.
// STRUCTURE
//  serial_addsub_pkg: state_t enum {IDLE, SHIFT, DONE}.
//  One sub-module: the existing fulladder, instantiated once as the bit cell (a, b, cin, s, cout).
//  Top level holds the FSM, shift registers, counter and output registers only.
// TESTING (WIDTH=8; check with ===, flags included)
//  1. Add 8'h35+8'h0A, out_ready=1 -> y=8'h3F, cout=0, ovf=0.
//     out_valid rises exactly 8 cycles after the accept edge.
//  2. Add 8'hFF+8'h01 -> y=8'h00, cout=1, ovf=0.
//     Sub 8'h10-8'h20 -> y=8'hF0, cout=0 (borrow), ovf=0.
//  3. Add 8'h7F+8'h01 -> ovf=1, y=8'h80; with SERIAL_ADDSUB_SAT_EN, y=8'h7F.
//     Sub 8'h80-8'h01 -> ovf=1, y=8'h7F; with SERIAL_ADDSUB_SAT_EN, y=8'h80.
//  4. Hold out_ready=0 for 5 cycles in DONE -> y, cout and ovf stay stable, in_ready=0.
//     Pulsing in_valid with new operands is ignored; the next accept follows the handshake.
//  5. Back-to-back: in_valid held high with a 2nd operand pair.
//     2nd accept occurs the cycle after the 1st out handshake; both results are correct.
//  6. Assert reset_n=0 three cycles into SHIFT -> in_ready=1, out_valid=0, y=0 immediately.
//     A fresh 8'h01+8'h01 then yields y=8'h02.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_fulladder.sv
// Single-bit full adder used as the serial arithmetic cell.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/subtract, one bit per clock, LSB first.
// Optional macro SERIAL_ADDSUB_SAT_EN: saturate y to the signed limit on overflow.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_s, fa_c;

    fulladder u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // On overflow the true result lies beyond the limit on the side of a's sign.
    function automatic logic [WIDTH-1:0] sat_limit(input logic sign);
        logic [WIDTH-1:0] lim;
        lim = {1'b0, {(WIDTH-1){1'b1}}};
        return sign ? ~lim : lim;
    endfunction

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                res_d   = WIDTH'({fa_s, res_q} >> 1);
                carry_d = fa_c;
                if (cnt_q == CNT_LAST) begin
                    // Last cycle: a_sr_q[0] is a's MSB and carry_q is the carry into the MSB.
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
`ifdef SERIAL_ADDSUB_SAT_EN
                    y_d     = (carry_q ^ fa_c) ? sat_limit(a_sr_q[0]) : res_d;
`else
                    y_d     = res_d;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub (WIDTH=8) with hand-computed results.
module tb_serial_addsub;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;

    int errors = 0;
    int checks = 0;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands and wait (bounded) for the accept edge.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic s);
        int n;
        a = av; b = bv; sub = s; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 30) begin
            step();
            n++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid, then compare the result.
    task automatic wait_result(input string tag, input logic [7:0] ey, input logic ec, input logic eo);
        int n;
        n = 0;
        while (!out_valid && n < 30) begin
            step();
            n++;
        end
        check({tag, "_lat"}, n, WIDTH);
        check({tag, "_y"}, {24'd0, y}, {24'd0, ey});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        check("drain_idle", {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    logic [7:0] sat_hi, sat_lo;
    logic [7:0] y_hold;

    initial begin
`ifdef SERIAL_ADDSUB_SAT_EN
        sat_hi = 8'h7F; sat_lo = 8'h80;
`else
        sat_hi = 8'h80; sat_lo = 8'h7F;
`endif
        reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        step(); step();
        check("rst_flags", {28'd0, in_ready, out_valid, cout, ovf}, 32'b1000);
        check("rst_y", {24'd0, y}, 32'd0);
        reset_n = 1'b1;
        step();

        // Basic add, carry and borrow cases
        start_op(8'h35, 8'h0A, 1'b0); wait_result("add35", 8'h3F, 1'b0, 1'b0); drain();
        start_op(8'hFF, 8'h01, 1'b0); wait_result("addFF", 8'h00, 1'b1, 1'b0); drain();
        start_op(8'h10, 8'h20, 1'b1); wait_result("sub10", 8'hF0, 1'b0, 1'b0); drain();

        // Signed overflow, optionally saturated
        start_op(8'h7F, 8'h01, 1'b0); wait_result("ovf_add", sat_hi, 1'b0, 1'b1); drain();
        start_op(8'h80, 8'h01, 1'b1); wait_result("ovf_sub", sat_lo, 1'b1, 1'b1); drain();

        // Backpressure in DONE with ignored in_valid pulses
        out_ready = 1'b0;
        start_op(8'h12, 8'h05, 1'b1); wait_result("bp", 8'h0D, 1'b1, 1'b0);
        y_hold = y;
        for (int i = 0; i < 5; i++) begin
            a = 8'h55; b = 8'h55; sub = 1'b0; in_valid = (i % 2 == 0);
            step();
            check("bp_hold", {22'd0, out_valid, in_ready, cout, ovf, y},
                  {22'd0, 1'b1, 1'b0, 1'b1, 1'b0, y_hold});
        end
        in_valid = 1'b0;
        drain();
        start_op(8'h20, 8'h30, 1'b0); wait_result("after_bp", 8'h50, 1'b0, 1'b0); drain();

        // Back-to-back with in_valid held high
        out_ready = 1'b1;
        start_op(8'h0F, 8'h01, 1'b0);
        a = 8'h05; b = 8'h07; sub = 1'b1; in_valid = 1'b1;
        wait_result("b2b1", 8'h10, 1'b0, 1'b0);
        step();
        check("b2b_idle", {30'd0, in_ready, out_valid}, 32'b10);
        step();
        in_valid = 1'b0;
        check("b2b_accept", {30'd0, in_ready, out_valid}, 32'b00);
        wait_result("b2b2", 8'hFE, 1'b0, 1'b0); drain();

        // Reset in the middle of SHIFT
        start_op(8'h11, 8'h22, 1'b0);
        step(); step();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_flags", {30'd0, in_ready, out_valid}, 32'b10);
        check("midrst_y", {24'd0, y}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        start_op(8'h01, 8'h01, 1'b0); wait_result("post_rst", 8'h02, 1'b0, 1'b0); drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
